// File: rtl/owr_pkg.sv
// Shared constants and state encoding for the 1-Wire temperature responder.
package owr_pkg;

    localparam logic [7:0] OWR_SKIP_ROM = 8'hCC;
    localparam logic [7:0] OWR_CONVERT  = 8'h44;
    localparam logic [7:0] OWR_READ_SCR = 8'hBE;

    // Reflected form of x^8+x^5+x^4+1
    localparam logic [7:0] OWR_CRC_POLY = 8'h8C;

    localparam logic [15:0] OWR_TEMP_POR = 16'h0550;

    // Scratchpad bytes 2..7, byte 2 in the low octet
    localparam logic [47:0] OWR_SCR_CONST = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRES_GAP,
        ST_PRES,
        ST_ROM_CMD,
        ST_FN_CMD,
        ST_CONVERT,
        ST_DONE,
        ST_TX
    } owr_state_e;

endpackage

// File: rtl/owr_crc8.sv
// Bit-serial Dallas CRC8, LSB-first input.
module owr_crc8
    import owr_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[0] ^ i_bit;
        crc_d = crc_q;
        if (i_clr) begin
            crc_d = 8'h00;
        end else if (i_en) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (fb ? OWR_CRC_POLY : 8'h00);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/owr_temp_slave.sv
// 1-Wire slave emulating one DS18B20: presence, Skip ROM, Convert T and
// Read Scratchpad with a serially generated CRC byte.
module owr_temp_slave
    import owr_pkg::*;
#(
    parameter int US_DIV       = 12,
    parameter int RST_MIN_US   = 400,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int TX0_US       = 30,
    parameter int CONV_US      = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_owr,
    output logic        o_owr,
    input  logic [15:0] i_temp,
    output logic        o_busy,
    output logic        o_conv_done
);

    localparam int DIV_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int LOW_W = $clog2(RST_MIN_US + 1);
    localparam int SLOT_US = (SAMPLE_US > TX0_US) ? SAMPLE_US : TX0_US;

    localparam logic [DIV_W-1:0] DIV_MAX     = DIV_W'(US_DIV - 1);
    localparam logic [LOW_W-1:0] LOW_MAX     = LOW_W'(RST_MIN_US);
    localparam logic [19:0]      PRES_WAIT_T = 20'(PRES_WAIT_US);
    localparam logic [19:0]      PRES_LEN_T  = 20'(PRES_LEN_US);
    localparam logic [19:0]      TX0_T       = 20'(TX0_US);
    localparam logic [19:0]      SLOT_T      = 20'(SLOT_US);
    localparam logic [19:0]      CONV_T      = 20'(CONV_US);

    logic             owr_s1_q, owr_s1_d;
    logic             owr_s2_q, owr_s2_d;
    logic             owr_prev_q, owr_prev_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [19:0]      us_q, us_d;
    logic [LOW_W-1:0] low_q, low_d;
    logic             rst_pend_q, rst_pend_d;
    owr_state_e       state_q, state_d;
    logic [6:0]       bit_q, bit_d;
    logic [6:0]       rx_q, rx_d;
    logic [63:0]      sr_q, sr_d;
    logic             slot_q, slot_d;
    logic             owr_q, owr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [19:0]      conv_q, conv_d;
    logic [15:0]      scr_q, scr_d;

    logic       tick;
    logic       fall;
    logic       slot_open;
    logic       fall_acc;
    logic       slot_end;
    logic [7:0] rx_byte;
    logic       tx_bit;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc;

    owr_crc8 u_crc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (crc_clr),
        .i_en  (crc_en),
        .i_bit (tx_bit),
        .o_crc (crc)
    );

    assign tick      = (div_q == DIV_MAX);
    assign fall      = owr_prev_q & ~owr_s2_q;
    assign slot_open = state_q inside {ST_ROM_CMD, ST_FN_CMD, ST_CONVERT, ST_DONE, ST_TX};
    assign fall_acc  = fall & ~slot_q & slot_open & ~rst_pend_q;
    assign slot_end  = slot_q & (us_q >= SLOT_T);
    assign rx_byte   = {owr_s2_q, rx_q};
    // CRC stops updating after bit 63 and is then read out bit by bit
    assign tx_bit    = (bit_q < 7'd64) ? sr_q[0] : crc[bit_q[2:0]];

    always_comb begin
        owr_s1_d   = i_owr;
        owr_s2_d   = owr_s1_q;
        owr_prev_d = owr_s2_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        us_d       = (tick && (us_q != 20'hFFFFF)) ? us_q + 20'd1 : us_q;
        low_d      = low_q;
        rst_pend_d = rst_pend_q;
        state_d    = state_q;
        bit_d      = bit_q;
        rx_d       = rx_q;
        sr_d       = sr_q;
        slot_d     = slot_q;
        owr_d      = owr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conv_d     = conv_q;
        scr_d      = scr_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        if (owr_s2_q) begin
            low_d = '0;
        end else if (tick && (low_q != LOW_MAX)) begin
            low_d = low_q + 1'b1;
        end
        if (!owr_s2_q && (low_q == LOW_MAX)) begin
            rst_pend_d = 1'b1;
        end

        // Conversion timer is independent of the FSM and survives bus resets
        if (busy_q && tick) begin
            if (conv_q <= 20'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                scr_d  = i_temp;
                if (state_q == ST_CONVERT) begin
                    state_d = ST_DONE;
                end
            end else begin
                conv_d = conv_q - 20'd1;
            end
        end

        if (owr_q && (state_q != ST_PRES) && (us_q >= TX0_T)) begin
            owr_d = 1'b0;
        end

        case (state_q)
            ST_PRES_GAP: begin
                if (us_q >= PRES_WAIT_T) begin
                    state_d = ST_PRES;
                    us_d    = '0;
                    owr_d   = 1'b1;
                end
            end
            ST_PRES: begin
                if (us_q >= PRES_LEN_T) begin
                    state_d = ST_ROM_CMD;
                    owr_d   = 1'b0;
                    bit_d   = '0;
                    slot_d  = 1'b0;
                end
            end
            default: ;
        endcase

        if (fall_acc) begin
            slot_d = 1'b1;
            us_d   = '0;
            if ((state_q == ST_CONVERT) || ((state_q == ST_TX) && !tx_bit)) begin
                owr_d = 1'b1;
            end
        end

        if (slot_end) begin
            slot_d = 1'b0;
            case (state_q)
                ST_ROM_CMD: begin
                    rx_d  = rx_byte[7:1];
                    bit_d = bit_q + 7'd1;
                    if (bit_q[2:0] == 3'd7) begin
                        bit_d   = '0;
                        state_d = (rx_byte == OWR_SKIP_ROM) ? ST_FN_CMD : ST_IDLE;
                    end
                end
                ST_FN_CMD: begin
                    rx_d  = rx_byte[7:1];
                    bit_d = bit_q + 7'd1;
                    if (bit_q[2:0] == 3'd7) begin
                        bit_d = '0;
                        case (rx_byte)
                            OWR_CONVERT: begin
                                state_d = ST_CONVERT;
                                busy_d  = 1'b1;
                                conv_d  = CONV_T;
                            end
                            OWR_READ_SCR: begin
                                state_d = ST_TX;
                                sr_d    = {OWR_SCR_CONST, scr_q};
                                crc_clr = 1'b1;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
                ST_TX: begin
                    crc_en = (bit_q < 7'd64);
                    sr_d   = {1'b0, sr_q[63:1]};
                    bit_d  = bit_q + 7'd1;
                    if (bit_q == 7'd71) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // A long low overrides everything; presence follows the release
        if (rst_pend_q) begin
            state_d = ST_IDLE;
            owr_d   = 1'b0;
            slot_d  = 1'b0;
            if (owr_s2_q) begin
                rst_pend_d = 1'b0;
                state_d    = ST_PRES_GAP;
                us_d       = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            owr_s1_q   <= 1'b1;
            owr_s2_q   <= 1'b1;
            owr_prev_q <= 1'b1;
            div_q      <= '0;
            us_q       <= '0;
            low_q      <= '0;
            rst_pend_q <= 1'b0;
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            rx_q       <= '0;
            sr_q       <= '0;
            slot_q     <= 1'b0;
            owr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= '0;
            scr_q      <= OWR_TEMP_POR;
        end else begin
            owr_s1_q   <= owr_s1_d;
            owr_s2_q   <= owr_s2_d;
            owr_prev_q <= owr_prev_d;
            div_q      <= div_d;
            us_q       <= us_d;
            low_q      <= low_d;
            rst_pend_q <= rst_pend_d;
            state_q    <= state_d;
            bit_q      <= bit_d;
            rx_q       <= rx_d;
            sr_q       <= sr_d;
            slot_q     <= slot_d;
            owr_q      <= owr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conv_q     <= conv_d;
            scr_q      <= scr_d;
        end
    end

    assign o_owr       = owr_q;
    assign o_busy      = busy_q;
    assign o_conv_done = done_q;

endmodule

// File: tb/tb_owr_temp_slave.sv
// Loopback bench: a behavioural 1-Wire master drives owr_temp_slave over a wired-AND bus.
`timescale 1ns/1ps
module tb_owr_temp_slave;

    localparam int US = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        m_pull = 1'b0;
    logic        owr_in;
    logic        o_owr;
    logic [15:0] temp   = 16'h0000;
    logic        busy;
    logic        conv_done;

    assign owr_in = ~(m_pull | o_owr);

    always #5 clk = ~clk;

    owr_temp_slave #(
        .US_DIV  (US),
        .CONV_US (100)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_owr       (owr_in),
        .o_owr       (o_owr),
        .i_temp      (temp),
        .o_busy      (busy),
        .o_conv_done (conv_done)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } vec_t;

    vec_t       sb_q[$];
    vec_t       tbl[10];
    int         n_cmp       = 0;
    int         n_bad       = 0;
    longint     cyc         = 0;
    longint     conv_cyc    = 0;
    int         conv_pulses = 0;
    int         owr_rises   = 0;
    logic       owr_last    = 1'b0;
    longint     last_fall   = 0;
    logic [7:0] run_crc     = 8'h00;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        owr_last <= o_owr;
        if (o_owr && !owr_last) owr_rises <= owr_rises + 1;
        if (conv_done) begin
            conv_pulses <= conv_pulses + 1;
            conv_cyc    <= cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d cycles expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s = %0d cycles", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_bit(input logic b);
        m_pull    = 1'b1;
        last_fall = cyc;
        wait_cyc(b ? 3 * US : 60 * US);
        m_pull = 1'b0;
        wait_cyc(b ? 59 * US : 2 * US);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        m_pull = 1'b1;
        wait_cyc(2 * US);
        m_pull = 1'b0;
        wait_cyc(11 * US);
        b = owr_in;
        wait_cyc(49 * US);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] v);
        vec_t e;
        e.name = name;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic read_compare();
        vec_t       e;
        logic [7:0] got;
        read_byte(got);
        run_crc = crc8_byte(run_crc, got);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0x%0h expected none", got);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, {24'h0, got}, {24'h0, e.val});
        end
    endtask

    // Master reset pulse, then measure the presence pulse against the release time
    task automatic bus_reset();
        longint rel;
        longint rise;
        int     k;
        m_pull = 1'b1;
        wait_cyc(480 * US);
        m_pull = 1'b0;
        rel = cyc;
        k = 0;
        while (!o_owr && k < 300 * US) begin
            wait_cyc(1);
            k++;
        end
        rise = cyc;
        // upper bound adds a few cycles of input synchroniser latency
        chk_rng("pres_start", rise - rel, 29 * US, 31 * US + 4);
        k = 0;
        while (o_owr && k < 300 * US) begin
            wait_cyc(1);
            k++;
        end
        chk_rng("pres_len", cyc - rise, 119 * US, 121 * US);
        wait_cyc(20 * US);
    endtask

    initial begin
        logic   b;
        logic   exp_bit;
        int     r0;
        int     k;
        logic [7:0] c;
        logic [7:0] scr_vals [8];

        scr_vals = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tbl[i].name = $sformatf("scr_b%0d", i);
            tbl[i].val  = scr_vals[i];
            c = crc8_byte(c, scr_vals[i]);
        end
        tbl[8].name = "scr_crc";
        tbl[8].val  = c;
        tbl[9].name = "after_72_bits";
        tbl[9].val  = 8'hFF;

        wait_cyc(5);
        chk("rst_o_owr", {31'h0, o_owr}, 32'h0);
        chk("rst_o_busy", {31'h0, busy}, 32'h0);
        chk("rst_o_conv_done", {31'h0, conv_done}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Read Scratchpad straight after reset gives the 85 C power-on value
        bus_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        expect_byte("por_b0", 8'h50);
        expect_byte("por_b1", 8'h05);
        read_compare();
        read_compare();

        // Convert T with 0x0191 on the input
        temp = 16'h0191;
        bus_reset();
        write_byte(8'hCC);
        write_byte(8'h44);
        chk("busy_set", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            exp_bit = (conv_pulses > 0);
            read_bit(b);
            chk($sformatf("conv_slot%0d", i), {31'h0, b}, {31'h0, exp_bit});
        end
        chk_rng("conv_time", conv_cyc - last_fall, 127 * US, 133 * US);
        chk("conv_pulse_count", conv_pulses, 1);
        chk("busy_clr", {31'h0, busy}, 32'h0);

        // Full 72-bit scratchpad read plus one idle byte
        bus_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        run_crc = 8'h00;
        for (int i = 0; i < 10; i++) expect_byte(tbl[i].name, tbl[i].val);
        for (int i = 0; i < 9; i++) read_compare();
        chk("crc_all9", {24'h0, run_crc}, 32'h0);
        read_compare();

        // Unsupported ROM command silences the slave until the next reset
        bus_reset();
        write_byte(8'h55);
        r0 = owr_rises;
        expect_byte("rom55_b0", 8'hFF);
        expect_byte("rom55_b1", 8'hFF);
        read_compare();
        read_compare();
        chk("rom55_quiet", owr_rises - r0, 0);

        // Reset in the middle of TX, then a fresh read restarts at byte 0
        bus_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int i = 0; i < 20; i++) read_bit(b);
        bus_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        expect_byte("restart_b0", 8'h91);
        expect_byte("restart_b1", 8'h01);
        read_compare();
        read_compare();

        // Chip reset during presence clears o_owr asynchronously
        m_pull = 1'b1;
        wait_cyc(480 * US);
        m_pull = 1'b0;
        k = 0;
        while (!o_owr && k < 300 * US) begin
            wait_cyc(1);
            k++;
        end
        chk("pres_active", {31'h0, o_owr}, 32'h1);
        wait_cyc(10 * US);
        rst_n = 1'b0;
        #1;
        chk("async_rst_owr", {31'h0, o_owr}, 32'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/owr_temp_slave.md
Name: owr_temp_slave

Overview:
- Synthesizable 1-Wire responder that models a single DS18B20-style temperature sensor.
- It is the bus-slave counterpart to the `temp` 1-Wire master and connects to its owr_out/owr_in pair.
- Used in sim_top loopback benches, and on-board as a stand-in sensor for brownout and hardware checks.
- Supports: bus reset with presence pulse, Skip ROM, Convert T, and Read Scratchpad with a CRC8 byte.

Parameters:
- US_DIV, 12, i_clk cycles per microsecond tick (12 MHz board clock).
- RST_MIN_US, 400, minimum bus-low time, in µs, recognised as a reset pulse.
- PRES_WAIT_US, 30, delay from bus release to presence start.
- PRES_LEN_US, 120, presence pulse length.
- SAMPLE_US, 30, sample point after a falling edge for master-write slots.
- TX0_US, 30, how long a 0 bit is held low in a read slot.
- CONV_US, 750000, Convert T duration; benches override this to 100.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous assert, active-low.
- i_owr  in  1  resolved bus level; 1 = released/high.
- o_owr  out  1  bus pull; 1 = drive bus low, 0 = release.
- i_temp  in  16  temperature, two's complement, 1/16 °C per LSB.
- o_busy  out  1  high while a conversion is running.
- o_conv_done  out  1  one-cycle pulse when a conversion completes.

Behaviour:
- Reset values: o_owr=0, o_busy=0, o_conv_done=0, state IDLE, scratchpad temperature 0x0550 (85 °C power-on value).
- Input conditioning:
  - i_owr passes through a 2-FF synchroniser; all logic uses the synchronised level.
  - A falling edge is detected on that level: 2-cycle latency from the pin.
- Timing: a free-running US_DIV prescaler produces a µs tick; slot timing uses a 20-bit µs counter that restarts on each falling edge.
- Bus reset detection runs in every state:
  - Bus low for ≥ RST_MIN_US aborts the current state, including CONVERT and TX.
  - On the next rising edge the FSM goes to PRES_GAP.
  - Our own o_owr never counts toward reset, because a pull is at most 120 µs.
- FSM states:
  - IDLE: wait for a reset pulse; all other slots are ignored.
  - PRES_GAP: after PRES_WAIT_US, go to PRES.
  - PRES: o_owr=1 for PRES_LEN_US, then go to ROM_CMD.
  - ROM_CMD: receive 8 bits, LSB first. 0xCC → FN_CMD; any other value → IDLE, silent until the next reset.
  - FN_CMD: receive 8 bits.
    - 0x44 → CONVERT.
    - 0xBE → TX, with the shift register loaded from the scratchpad.
    - Other → IDLE.
  - CONVERT:
    - o_busy=1 and the µs down-counter is loaded with CONV_US.
    - Read slots answer 0 while busy.
    - At terminal count: latch i_temp into scratchpad bytes 0–1, pulse o_conv_done, set o_busy=0, go to DONE.
  - DONE: read slots answer 1; stay until a reset.
  - TX: 72 bits, LSB first, byte 0 first. After bit 71 → IDLE; further read slots return 1 (bus released).
- Write-slot receive: sample the bus SAMPLE_US after the falling edge; low = 0, high = 1.
- Read-slot transmit:
  - On the falling edge, if the bit is 0, o_owr=1 for TX0_US, then release.
  - If the bit is 1, o_owr stays 0.
  - o_owr rises at most 1 cycle after the falling edge is detected.
- Scratchpad contents:
  - Byte 0: T[7:0]; byte 1: T[15:8].
  - Bytes 2–7: 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10.
  - Byte 8: Dallas CRC8 (x^8+x^5+x^4+1, reflected, init 0x00) over bytes 0–7.
  - The CRC is computed serially while shifting out, so byte 8 is streamed from the CRC register.
- Conversion/temperature interaction:
  - The conversion timer keeps running if a bus reset arrives, so o_busy stays high.
  - The scratchpad updates on completion regardless of FSM state.
  - A new 0x44 while busy restarts the timer.
- Reading during a conversion: Read Scratchpad returns the old temperature.
- A falling edge that occurs before the previous slot has finished is ignored; it does not resynchronise the bit counter.

Decomposition:
- Package owr_pkg holds:
  - command constants: OWR_SKIP_ROM=8'hCC, OWR_CONVERT=8'h44, OWR_READ_SCR=8'hBE;
  - the state enum;
  - the scratchpad constant bytes.
- Sub-module owr_crc8: bit-serial CRC8 with clr, en and bit inputs, and an 8-bit crc output.

Test Plan:
1. Master drives 480 µs low, then releases → o_owr low-pulse starting 30±1 µs after release, lasting 120±1 µs.
2. Reset, 0xCC, 0x44 with CONV_US=100 and i_temp=0x0191 → o_busy=1. Read slots return 0 until o_conv_done, which comes 100 µs after the last command bit; then they return 1.
3. Reset, 0xCC, 0xBE after test 2 → 72 bits read: bytes 0x91, 0x01, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, then CRC. The bench checks that CRC8 over all 9 bytes equals 0x00.
4. Reset, 0xCC, 0xBE immediately after i_rst → bytes 0–1 read back as 0x50, 0x05.
5. Reset, ROM command 0x55 → no bus activity on the following 16 slots; a new reset still yields presence.
6. Reset pulse issued at bit 20 of the scratchpad read → TX aborts and presence is issued. A following 0xCC/0xBE restarts at byte 0. Asserting i_rst low mid-presence forces o_owr=0 at once.
